// File: rtl/card_shoe.sv
// card_shoe: single 52-card deck for the blackjack datapath.
//   Holds a dealt-card mask and serves one card per accepted request.
//   A free-running LFSR picks a start index (rejecting 52..63), then
//   linear probing walks to the next undealt card. The deck refills on
//   shuffle, or automatically when a request arrives with no cards left.
// Ports:
//   clk, reset (async, active low)
//   req, shuffle, seq_mode : request controls, sampled only while ready=1
//   ready                  : IDLE, accepting req/shuffle
//   card_valid             : one-cycle pulse, card_* hold a new card
//   card_value/rank/suit   : last dealt card (held until the next one)
//   cards_left             : undealt cards, 0..52
//   reshuffled             : one-cycle pulse after a refill
module card_shoe #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       shuffle,
  input  logic       seq_mode,
  output logic       ready,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [5:0] cards_left,
  output logic       reshuffled
);

  // An all-zero Galois LFSR would lock up.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, PICK, PROBE, DEAL} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [51:0] mask_q, mask_d;
  logic [5:0]  left_q, left_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  value_q, value_d;
  logic [3:0]  rank_q, rank_d;
  logic [1:0]  suit_q, suit_d;
  logic        resh_q, resh_d;

  // idx -> suit/rank via compare chain, avoiding a divider.
  logic [1:0] suit_c;
  logic [5:0] base_c, off_c;
  logic [3:0] rank_c, value_c;

  always_comb begin
    if (idx_q >= 6'd39)      begin suit_c = 2'd3; base_c = 6'd39; end
    else if (idx_q >= 6'd26) begin suit_c = 2'd2; base_c = 6'd26; end
    else if (idx_q >= 6'd13) begin suit_c = 2'd1; base_c = 6'd13; end
    else                     begin suit_c = 2'd0; base_c = 6'd0;  end
    off_c   = idx_q - base_c;
    rank_c  = off_c[3:0] + 4'd1;
    value_c = (rank_c > 4'd10) ? 4'd10 : rank_c;
  end

  always_comb begin
    // 16-bit Galois LFSR, advances every cycle regardless of state.
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    state_d = state_q;
    mask_d  = mask_q;
    left_d  = left_q;
    idx_d   = idx_q;
    value_d = value_q;
    rank_d  = rank_q;
    suit_d  = suit_q;
    resh_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (shuffle) begin
          mask_d = '0;
          left_d = 6'd52;
          resh_d = 1'b1;
        end else if (req) begin
          if (left_q == 6'd0) begin
            mask_d = '0;
            left_d = 6'd52;
            resh_d = 1'b1;
          end
          state_d = PICK;
        end
      end
      PICK: begin
        if (seq_mode) begin
          idx_d   = 6'd0;
          state_d = PROBE;
        end else if (lfsr_q[5:0] < 6'd52) begin
          idx_d   = lfsr_q[5:0];
          state_d = PROBE;
        end
      end
      PROBE: begin
        // Terminates: at least one card is undealt on entry.
        if (!mask_q[idx_q]) begin
          mask_d[idx_q] = 1'b1;
          left_d        = left_q - 6'd1;
          value_d       = value_c;
          rank_d        = rank_c;
          suit_d        = suit_c;
          state_d       = DEAL;
        end else begin
          idx_d = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
        end
      end
      DEAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      mask_q  <= '0;
      left_q  <= 6'd52;
      idx_q   <= 6'd0;
      value_q <= 4'd0;
      rank_q  <= 4'd0;
      suit_q  <= 2'd0;
      resh_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      mask_q  <= mask_d;
      left_q  <= left_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
      resh_q  <= resh_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign card_valid = (state_q == DEAL);
  assign card_value = value_q;
  assign card_rank  = rank_q;
  assign card_suit  = suit_q;
  assign cards_left = left_q;
  assign reshuffled = resh_q;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: reset values, sequential dealing through a
// full deck, auto-refill, shuffle priority, async reset mid-probe and a
// random-mode full deck with ignored req noise.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, shuffle, seq_mode;
  logic       ready, card_valid, reshuffled;
  logic [3:0] card_value, card_rank;
  logic [1:0] card_suit;
  logic [5:0] cards_left;

  int n_cmp = 0;
  int n_bad = 0;

  card_shoe #(.SEED(16'hACE1)) dut (
    .clk(clk), .reset(rst_n), .req(req), .shuffle(shuffle),
    .seq_mode(seq_mode), .ready(ready), .card_valid(card_valid),
    .card_value(card_value), .card_rank(card_rank), .card_suit(card_suit),
    .cards_left(cards_left), .reshuffled(reshuffled)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Called at a negedge with ready=1. Returns at a negedge back in IDLE.
  // lat = edges from the accepting edge to the edge ending card_valid.
  task automatic do_req(input bit noisy, output int lat, output bit resh_seen);
    lat = -1;
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    resh_seen = reshuffled;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (card_valid) begin
        lat = k + 1;
        req = 1'b0;
        chk("ready_low_in_deal", int'(ready), 0);
        break;
      end
      if (noisy) req = 1'($urandom_range(0, 1));
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int n;      // deal number (1-based) in sequential mode
    int rank;
    int suit;
    int value;
    int left;
    int lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int  lat;
    bit  rs;
    bit [51:0] seen;
    int  id;

    tbl[0] = '{n: 1,  rank: 1,  suit: 0, value: 1,  left: 51, lat: 3};
    tbl[1] = '{n: 2,  rank: 2,  suit: 0, value: 2,  left: 50, lat: 4};
    tbl[2] = '{n: 3,  rank: 3,  suit: 0, value: 3,  left: 49, lat: 5};
    tbl[3] = '{n: 13, rank: 13, suit: 0, value: 10, left: 39, lat: 15};
    tbl[4] = '{n: 52, rank: 13, suit: 3, value: 10, left: 0,  lat: 54};

    req = 0; shuffle = 0; seq_mode = 1; rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_left", int'(cards_left), 52);
    chk("rst_rank", int'(card_rank), 0);
    chk("rst_value", int'(card_value), 0);
    chk("rst_resh", int'(reshuffled), 0);
    rst_n = 1;
    @(negedge clk);

    // Sequential mode, full deck.
    for (int i = 1; i <= 52; i++) begin
      do_req(1'b0, lat, rs);
      chk("seq_lat", lat, i + 2);
      for (int t = 0; t < 5; t++) begin
        if (tbl[t].n == i) begin
          chk("seq_rank", int'(card_rank), tbl[t].rank);
          chk("seq_suit", int'(card_suit), tbl[t].suit);
          chk("seq_value", int'(card_value), tbl[t].value);
          chk("seq_left", int'(cards_left), tbl[t].left);
          chk("seq_lat_tbl", lat, tbl[t].lat);
        end
      end
    end
    chk("empty_ready", int'(ready), 1);

    // 53rd request refills the deck automatically.
    do_req(1'b0, lat, rs);
    chk("auto_resh", int'(rs), 1);
    chk("auto_left", int'(cards_left), 51);
    chk("auto_rank", int'(card_rank), 1);
    chk("auto_suit", int'(card_suit), 0);
    chk("auto_lat", lat, 3);
    chk("auto_resh_done", int'(reshuffled), 0);

    // Nine more: 10 dealt since refill, last is rank10/suit0.
    for (int i = 0; i < 9; i++) do_req(1'b0, lat, rs);
    chk("ten_left", int'(cards_left), 42);

    // shuffle beats req.
    shuffle = 1; req = 1;
    @(posedge clk);
    @(negedge clk);
    shuffle = 0; req = 0;
    chk("shuf_left", int'(cards_left), 52);
    chk("shuf_resh", int'(reshuffled), 1);
    chk("shuf_ready", int'(ready), 1);
    chk("shuf_valid", int'(card_valid), 0);
    chk("shuf_rank_held", int'(card_rank), 10);
    chk("shuf_value_held", int'(card_value), 10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("shuf_no_valid", int'(card_valid), 0);
      chk("shuf_idle", int'(ready), 1);
    end

    // Async reset while probing past 5 dealt cards.
    for (int i = 0; i < 5; i++) do_req(1'b0, lat, rs);
    chk("pre_rst_rank", int'(card_rank), 5);
    req = 1;
    @(posedge clk);
    @(negedge clk);
    req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("in_probe_busy", int'(ready), 0);
    rst_n = 0;
    #1;
    chk("arst_ready", int'(ready), 1);
    chk("arst_valid", int'(card_valid), 0);
    chk("arst_left", int'(cards_left), 52);
    chk("arst_rank", int'(card_rank), 0);
    chk("arst_suit", int'(card_suit), 0);
    chk("arst_value", int'(card_value), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Random mode, full deck, req noise while busy.
    seq_mode = 0;
    seen = '0;
    for (int i = 0; i < 52; i++) begin
      do_req(1'b1, lat, rs);
      chk("rnd_lat_ge3", int'(lat >= 3), 1);
      chk("rnd_value", int'(card_value), (card_rank > 10) ? 10 : int'(card_rank));
      chk("rnd_rank_range", int'(card_rank >= 1 && card_rank <= 13), 1);
      id = int'(card_suit) * 13 + int'(card_rank) - 1;
      if (id >= 0 && id < 52) begin
        chk("rnd_unique", int'(seen[id]), 0);
        seen[id] = 1'b1;
      end
      chk("rnd_left", int'(cards_left), 51 - i);
    end
    chk("rnd_all_seen", int'(&seen), 1);
    chk("rnd_ready", int'(ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
# card_shoe

Card source for the blackjack game datapath. It holds one 52-card deck as a dealt-card mask and answers single-card requests over a ready/req/valid handshake. It draws a pseudo-random undealt card with a free-running LFSR and linear probing, and refills the deck when a request arrives with no cards left. The game FSM requests one card per hit, double or deal step and consumes the returned value, rank and suit.

## Interface
Parameters:
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  1  card request; sampled only while ready=1
- shuffle  input  1  return all cards to the deck; sampled only while ready=1; has priority over req
- seq_mode  input  1  1 = deterministic dealing (probe always starts at index 0)
- ready  output  1  block is in IDLE and accepts req/shuffle
- card_valid  output  1  one-cycle pulse: card_* fields hold a new card
- card_value  output  4  blackjack value: 1 for ace, 2–10, 10 for J/Q/K
- card_rank  output  4  rank 1–13
- card_suit  output  2  suit 0–3
- cards_left  output  6  number of undealt cards, 0–52
- reshuffled  output  1  one-cycle pulse when the deck is refilled, either by shuffle or automatically

## Operation
- Deck index idx is 0..51. suit = idx/13 and rank = (idx mod 13)+1, both derived through a compare chain (no divider). value = (rank>10) ? 10 : rank.
- LFSR: 16-bit Galois, mask 16'hB400. It advances every clock in every state and returns to SEED on reset.
- State IDLE (ready=1):
  - If shuffle: clear the mask, set cards_left=52, pulse reshuffled, stay in IDLE. Any req in the same cycle is ignored.
  - Else if req and cards_left==0: clear the mask, set cards_left=52, pulse reshuffled, go to PICK.
  - Else if req: go to PICK.
- State PICK:
  - If seq_mode: idx ← 0, go to PROBE.
  - Else if lfsr[5:0] < 52: idx ← lfsr[5:0], go to PROBE.
  - Otherwise stay in PICK (rejection sampling).
- State PROBE:
  - If mask[idx]==0: set mask[idx], decrement cards_left, latch card_value/rank/suit, go to DEAL.
  - Otherwise idx ← (idx==51) ? 0 : idx+1 and stay in PROBE.
  - The probe always terminates because cards_left ≥ 1 on entry.
- State DEAL: card_valid=1 for this cycle only, then return to IDLE.
- card_* fields hold their value until the next card is latched. They are never cleared by shuffle.
- seq_mode is sampled in PICK only. Changing it mid-request affects the next request.
- req or shuffle outside IDLE is ignored. There is no queueing, so the requester must wait for ready.
- A card is never dealt twice between refills. 52 consecutive deals return each idx exactly once.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, so ready=1
  - card_valid=0, card_value=0, card_rank=0, card_suit=0
  - mask cleared, cards_left=52, reshuffled=0
- Reset mid-request aborts the deal. No card is consumed and cards_left returns to 52.
- Latency, counted from the edge that samples req to the edge that ends the card_valid cycle:
  - Minimum: 3 edges (PICK 1, PROBE 1, DEAL 1).
  - seq_mode with n cards already dealt in order: n+3 edges.
  - Random mode: unbounded rejection in PICK plus at most 52 probe cycles.
- ready is low from the edge after req is accepted until the edge ending DEAL. ready=1 and card_valid=1 never occur in the same cycle.
- cards_left updates at the edge entering DEAL, so it is already decremented while card_valid=1.
- reshuffled is high for the cycle following the refill edge.

## Test plan
- Reset: drive reset=0 mid-PROBE → ready=1, card_valid=0, cards_left=52 immediately (asynchronously), all card fields 0.
- seq_mode with 3 requests → cards (rank1,suit0,value1), (rank2,suit0,value2), (rank3,suit0,value3); card_valid at 3, 4 and 5 edges after each accepted req; cards_left 51, 50, 49.
- seq_mode with 52 requests → the 13th card is rank13/suit0/value10, the 52nd is rank13/suit3; cards_left=0; ready=1.
- 53rd request on an empty deck → reshuffled pulses, cards_left goes 52→51, card rank1/suit0.
- Random mode with 52 requests → all 52 (suit,rank) pairs appear exactly once; each latency ≥3 edges; req pulses sent while ready=0 have no effect on the results.
- shuffle and req asserted together after 10 deals → cards_left=52, reshuffled=1, no card_valid, ready stays 1.
